// File: rtl/tile_blit_pkg.sv
// Shared types and helpers for the tile blitter: FSM states, pixel payload, mirroring.
package tile_blit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EMIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned BYTES_PER_PIXEL = 3;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Maps a tile-local index onto its on-screen offset, optionally mirrored.
    function automatic logic [31:0] mirror_coord(input logic [31:0] idx,
                                                 input logic [31:0] size,
                                                 input logic        flip);
        return flip ? (size - 32'd1 - idx) : idx;
    endfunction

endpackage

// File: rtl/tile_rom_fetch.sv
// Byte sequencer: reads the R,G,B bytes of one pixel from a byte ROM with ROM_LAT wait states.
module tile_rom_fetch
    import tile_blit_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              kick,
    input  logic              clear,
    input  logic [ADDR_W-1:0] pix_base,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output rgb_t              rgb_c,
    output logic              cap_done_c
);

    localparam int unsigned WAIT_W = (ROM_LAT > 0) ? $clog2(ROM_LAT + 1) : 1;

    logic              active_q;
    logic [1:0]        byte_q;
    logic [WAIT_W-1:0] wait_q;
    logic [7:0]        r_q;
    logic [7:0]        g_q;
    logic              cap_c;

    // A byte is captured on the edge closing its last presentation cycle.
    assign cap_c      = active_q && (wait_q == WAIT_W'(ROM_LAT));
    assign cap_done_c = cap_c && (byte_q == 2'(BYTES_PER_PIXEL - 1));
    assign rgb_c      = rgb_t'({r_q, g_q, rom_data});

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            active_q <= 1'b0;
            byte_q   <= 2'd0;
            wait_q   <= '0;
            rom_addr <= '0;
            r_q      <= 8'd0;
            g_q      <= 8'd0;
        end else if (clear) begin
            active_q <= 1'b0;
        end else if (kick) begin
            active_q <= 1'b1;
            byte_q   <= 2'd0;
            wait_q   <= '0;
            rom_addr <= pix_base;
        end else if (cap_c) begin
            case (byte_q)
                2'd0:    r_q <= rom_data;
                2'd1:    g_q <= rom_data;
                default: ;
            endcase
            rom_addr <= rom_addr + ADDR_W'(1);
            wait_q   <= '0;
            byte_q   <= byte_q + 2'd1;
            if (cap_done_c) begin
                active_q <= 1'b0;
            end
        end else if (active_q) begin
            wait_q <= wait_q + WAIT_W'(1);
        end
    end

endmodule

// File: rtl/tile_blitter.sv
// Tile-to-framebuffer blitter with mirroring, pixel handshake and abort.
// Optional colour-key transparency is enabled by defining TILE_BLIT_KEY_EN.
module tile_blitter
    import tile_blit_pkg::*;
#(
    parameter int unsigned TILE_W  = 8,
    parameter int unsigned TILE_H  = 8,
    parameter int unsigned COORD_W = 8,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               abort,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [COORD_W-1:0] x_pos,
    input  logic [COORD_W-1:0] y_pos,
    input  logic               flip_x,
    input  logic               flip_y,
    input  logic [23:0]        key_rgb,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [7:0]         rom_data,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [23:0]        pix_rgb,
    output logic               busy,
    output logic               done
);

    localparam int unsigned C_W = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int unsigned R_W = (TILE_H > 1) ? $clog2(TILE_H) : 1;

    state_t             state_q, state_d;
    logic [C_W-1:0]     c_q, c_d;
    logic [R_W-1:0]     r_q, r_d;
    logic [ADDR_W-1:0]  pix_addr_q, pix_addr_d;
    logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d;
    logic               fx_q, fx_d, fy_q, fy_d;
    logic               pix_valid_d, done_d, busy_d;
    logic [COORD_W-1:0] pix_x_d, pix_y_d;
    logic [23:0]        pix_rgb_d;
    logic               kick_c, clear_c, cap_done_c, keyed_c, advance_c, last_c;
    logic [ADDR_W-1:0]  kick_addr_c;
    rgb_t               fetch_rgb_c;

    tile_rom_fetch #(
        .ADDR_W  (ADDR_W),
        .ROM_LAT (ROM_LAT)
    ) u_fetch (
        .clk        (clk),
        .resetn     (resetn),
        .kick       (kick_c),
        .clear      (clear_c),
        .pix_base   (kick_addr_c),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rgb_c      (fetch_rgb_c),
        .cap_done_c (cap_done_c)
    );

`ifdef TILE_BLIT_KEY_EN
    assign keyed_c = (fetch_rgb_c == rgb_t'(key_rgb));
`else
    logic unused_key_c;
    assign unused_key_c = ^key_rgb;
    assign keyed_c      = 1'b0;
`endif

    assign clear_c   = abort && (state_q != ST_IDLE);
    // A keyed pixel sits in EMIT with pix_valid low and advances without a transfer.
    assign advance_c = (state_q == ST_EMIT) && (!pix_valid || pix_ready);
    assign last_c    = (r_q == R_W'(TILE_H - 1)) && (c_q == C_W'(TILE_W - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)      state_d = ST_FETCH;
            ST_FETCH: if (cap_done_c) state_d = ST_EMIT;
            ST_EMIT:  if (advance_c)  state_d = last_c ? ST_DONE : ST_FETCH;
            ST_DONE:                  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
        if (clear_c) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        pix_valid_d = 1'b0;
        done_d      = 1'b0;
        busy_d      = (state_d != ST_IDLE);
        pix_x_d     = pix_x;
        pix_y_d     = pix_y;
        pix_rgb_d   = pix_rgb;
        kick_c      = 1'b0;
        kick_addr_c = pix_addr_q;
        pix_addr_d  = pix_addr_q;
        c_d         = c_q;
        r_d         = r_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        fx_d        = fx_q;
        fy_d        = fy_q;
        if (!clear_c) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        kick_c      = 1'b1;
                        kick_addr_c = base_addr;
                        pix_addr_d  = base_addr;
                        x0_d        = x_pos;
                        y0_d        = y_pos;
                        fx_d        = flip_x;
                        fy_d        = flip_y;
                        c_d         = '0;
                        r_d         = '0;
                    end
                end
                ST_FETCH: begin
                    if (cap_done_c) begin
                        pix_valid_d = !keyed_c;
                        pix_x_d = x0_q + COORD_W'(mirror_coord(32'(c_q), 32'(TILE_W), fx_q));
                        pix_y_d = y0_q + COORD_W'(mirror_coord(32'(r_q), 32'(TILE_H), fy_q));
                        pix_rgb_d = fetch_rgb_c;
                    end
                end
                ST_EMIT: begin
                    if (!advance_c) begin
                        pix_valid_d = 1'b1;
                    end else if (last_c) begin
                        done_d = 1'b1;
                    end else begin
                        kick_c      = 1'b1;
                        kick_addr_c = pix_addr_q + ADDR_W'(BYTES_PER_PIXEL);
                        pix_addr_d  = kick_addr_c;
                        if (c_q == C_W'(TILE_W - 1)) begin
                            c_d = '0;
                            r_d = r_q + R_W'(1);
                        end else begin
                            c_d = c_q + C_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pix_valid  <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_rgb    <= 24'd0;
            pix_addr_q <= '0;
            c_q        <= '0;
            r_q        <= '0;
            x0_q       <= '0;
            y0_q       <= '0;
            fx_q       <= 1'b0;
            fy_q       <= 1'b0;
        end else begin
            pix_valid  <= pix_valid_d;
            done       <= done_d;
            busy       <= busy_d;
            pix_x      <= pix_x_d;
            pix_y      <= pix_y_d;
            pix_rgb    <= pix_rgb_d;
            pix_addr_q <= pix_addr_d;
            c_q        <= c_d;
            r_q        <= r_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            fx_q       <= fx_d;
            fy_q       <= fy_d;
        end
    end

endmodule

// File: tb/tb_tile_blitter.sv
// Self-checking bench for tile_blitter against a raster-order reference model of the tile.
module tb_tile_blitter;

    localparam int TILE_W = 8;
    localparam int TILE_H = 8;
    localparam int NPIX   = TILE_W * TILE_H;
    localparam int PERIOD = 3 * (1 + 1) + 1;

    typedef struct packed {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [23:0] rgb;
    } pix_t;

    logic        clk = 1'b0;
    logic        resetn, start, abort, flip_x, flip_y, pix_ready;
    logic [11:0] base_addr, rom_addr;
    logic [7:0]  x_pos, y_pos, pix_x, pix_y, rom_data;
    logic [23:0] key_rgb, pix_rgb;
    logic        pix_valid, busy, done;

    logic [7:0]  rom_mem [0:4095];

    int   tests = 0;
    int   fails = 0;
    pix_t obs_q[$];
    pix_t exp_q[$];
    int   r_n, r_done_cyc, r_ndone;
    bit   r_stable, r_timeout, r_end_valid, r_rst_valid, r_rst_busy;

    tile_blitter #(
        .TILE_W (8), .TILE_H (8), .COORD_W (8), .ADDR_W (12), .ROM_LAT (1)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .flip_x    (flip_x),
        .flip_y    (flip_y),
        .key_rgb   (key_rgb),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_rgb   (pix_rgb),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // One-cycle-latency ROM
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic rom_fill_linear();
        for (int i = 0; i < 4096; i++) rom_mem[i] = 8'(i);
    endtask

    task automatic rom_fill_random();
        for (int i = 0; i < 4096; i++) rom_mem[i] = 8'($urandom);
    endtask

    // Reference: every tile pixel in raster order, read and placed directly from the rules.
    task automatic build_expected(input logic [11:0] b, input logic [7:0] x, input logic [7:0] y,
                                  input logic fx, input logic fy);
        int          r, c;
        logic [11:0] a;
        pix_t        p;
        exp_q.delete();
        for (int idx = 0; idx < NPIX; idx++) begin
            r = idx / TILE_W;
            c = idx % TILE_W;
            a = 12'(int'(b) + 3 * idx);
            p.rgb = {rom_mem[a], rom_mem[12'(a + 12'd1)], rom_mem[12'(a + 12'd2)]};
            p.x = 8'(int'(x) + (fx ? TILE_W - 1 - c : c));
            p.y = 8'(int'(y) + (fy ? TILE_H - 1 - r : r));
`ifdef TILE_BLIT_KEY_EN
            if (p.rgb == key_rgb) continue;
`endif
            exp_q.push_back(p);
        end
    endtask

    // Drives one tile and records transfers; cycle index counts edges after the start edge.
    task automatic run_tile(input logic [11:0] b, input logic [7:0] x, input logic [7:0] y,
                            input logic fx, input logic fy,
                            input int stall_at, input int stall_len, input int abort_at, input int rst_at);
        int   stalled;
        bit   hit;
        pix_t snap, cur;
        obs_q.delete();
        r_n = 0; r_done_cyc = -1; r_ndone = 0; r_stable = 1; r_timeout = 1;
        r_end_valid = 0; r_rst_valid = 1; r_rst_busy = 1;
        stalled = 0; hit = 0; snap = '0;
        @(negedge clk);
        base_addr = b; x_pos = x; y_pos = y; flip_x = fx; flip_y = fy;
        start = 1'b1; pix_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base_addr = 12'($urandom); x_pos = 8'($urandom); y_pos = 8'($urandom);
        flip_x = 1'($urandom); flip_y = 1'($urandom);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            cur = {pix_x, pix_y, pix_rgb};
            abort = 1'b0;
            resetn = 1'b1;
            if (done) begin
                r_ndone++;
                if (r_done_cyc < 0) r_done_cyc = cyc;
            end
            if (cyc > 0 && !busy) begin
                r_timeout = 0;
                r_end_valid = pix_valid;
                break;
            end
            pix_ready = 1'b1;
            if (pix_valid) begin
                if (!hit && r_n == abort_at) begin
                    abort = 1'b1;
                    hit = 1;
                end else if (!hit && r_n == rst_at) begin
                    resetn = 1'b0;
                    hit = 1;
                    #1;
                    r_rst_valid = pix_valid;
                    r_rst_busy = busy;
                end else if (r_n == stall_at && stalled < stall_len) begin
                    pix_ready = 1'b0;
                    if (stalled == 0) snap = cur;
                    else if (cur !== snap) r_stable = 0;
                    stalled++;
                end else begin
                    if (r_n == stall_at && stalled > 0 && cur !== snap) r_stable = 0;
                    obs_q.push_back(cur);
                    r_n++;
                end
            end else if (r_n == stall_at && stalled > 0 && stalled < stall_len) begin
                r_stable = 0;
            end
            @(negedge clk);
        end
        abort = 1'b0;
        resetn = 1'b1;
        pix_ready = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #12;
        tests++;
        if ({pix_valid, busy, done} !== 3'b000) begin
            fails++;
            $display("FAIL reset_ctrl got %b exp 000", {pix_valid, busy, done});
        end
        tests++;
        if ({pix_x, pix_y, pix_rgb} !== 40'd0) begin
            fails++;
            $display("FAIL reset_pix got %h exp 0", {pix_x, pix_y, pix_rgb});
        end
        tests++;
        if (rom_addr !== 12'd0) begin
            fails++;
            $display("FAIL reset_rom_addr got %h exp 000", rom_addr);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_basic();
        pix_t f, l;
        rom_fill_linear();
        run_tile(12'd0, 8'd10, 8'd20, 1'b0, 1'b0, -1, 0, -1, -1);
        build_expected(12'd0, 8'd10, 8'd20, 1'b0, 1'b0);
        tests++;
        if (r_timeout || r_n != exp_q.size()) begin
            fails++;
            $display("FAIL basic_count got %0d (timeout %0d) exp %0d", r_n, r_timeout, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests++;
            if (obs_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL basic_pix[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
        f = (obs_q.size() > 0) ? obs_q[0] : '0;
        l = (obs_q.size() > 0) ? obs_q[obs_q.size() - 1] : '0;
        tests++;
        if (f !== {8'd10, 8'd20, 24'h000102}) begin
            fails++;
            $display("FAIL basic_first got %h exp %h", f, {8'd10, 8'd20, 24'h000102});
        end
        tests++;
        if (l !== {8'd17, 8'd27, 24'hBDBEBF}) begin
            fails++;
            $display("FAIL basic_last got %h exp %h", l, {8'd17, 8'd27, 24'hBDBEBF});
        end
        tests++;
        if (r_done_cyc != NPIX * PERIOD || r_ndone != 1) begin
            fails++;
            $display("FAIL basic_done got cycle %0d x%0d exp cycle %0d x1", r_done_cyc, r_ndone, NPIX * PERIOD);
        end
    endtask

    task automatic test_flip();
        pix_t f;
        run_tile(12'd0, 8'd10, 8'd20, 1'b1, 1'b1, -1, 0, -1, -1);
        build_expected(12'd0, 8'd10, 8'd20, 1'b1, 1'b1);
        tests++;
        if (r_timeout || r_n != exp_q.size()) begin
            fails++;
            $display("FAIL flip_count got %0d exp %0d", r_n, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests++;
            if (obs_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL flip_pix[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
        f = (obs_q.size() > 0) ? obs_q[0] : '0;
        tests++;
        if (f !== {8'd17, 8'd27, 24'h000102}) begin
            fails++;
            $display("FAIL flip_first got %h exp %h", f, {8'd17, 8'd27, 24'h000102});
        end
    endtask

    task automatic test_stall();
        run_tile(12'd0, 8'd10, 8'd20, 1'b0, 1'b0, 3, 5, -1, -1);
        build_expected(12'd0, 8'd10, 8'd20, 1'b0, 1'b0);
        tests++;
        if (r_timeout || r_n != exp_q.size()) begin
            fails++;
            $display("FAIL stall_count got %0d exp %0d", r_n, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests++;
            if (obs_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL stall_pix[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
        tests++;
        if (!r_stable) begin
            fails++;
            $display("FAIL stall_hold got unstable exp stable");
        end
        tests++;
        if (r_done_cyc != NPIX * PERIOD + 5) begin
            fails++;
            $display("FAIL stall_done got %0d exp %0d", r_done_cyc, NPIX * PERIOD + 5);
        end
    endtask

    task automatic test_wrap();
        pix_t p1, p2, p0;
        run_tile(12'hFFF, 8'd254, 8'd20, 1'b0, 1'b0, -1, 0, -1, -1);
        build_expected(12'hFFF, 8'd254, 8'd20, 1'b0, 1'b0);
        tests++;
        if (r_timeout || r_n != exp_q.size()) begin
            fails++;
            $display("FAIL wrap_count got %0d exp %0d", r_n, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests++;
            if (obs_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL wrap_pix[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
        p0 = (obs_q.size() > 2) ? obs_q[0] : '0;
        p1 = (obs_q.size() > 2) ? obs_q[1] : '0;
        p2 = (obs_q.size() > 2) ? obs_q[2] : '0;
        tests++;
        if ({p0.x, p1.x, p2.x} !== {8'd254, 8'd255, 8'd0}) begin
            fails++;
            $display("FAIL wrap_x got %0d,%0d,%0d exp 254,255,0", p0.x, p1.x, p2.x);
        end
        tests++;
        if (p0.rgb !== 24'hFF0001) begin
            fails++;
            $display("FAIL wrap_addr got %h exp ff0001", p0.rgb);
        end
    endtask

    task automatic test_abort();
        run_tile(12'd0, 8'd10, 8'd20, 1'b0, 1'b0, -1, 0, 10, -1);
        tests++;
        if (r_timeout || r_n != 10 || r_ndone != 0 || r_end_valid) begin
            fails++;
            $display("FAIL abort got xfers %0d dones %0d valid %0d exp 10 0 0", r_n, r_ndone, r_end_valid);
        end
        run_tile(12'd0, 8'd10, 8'd20, 1'b0, 1'b0, -1, 0, -1, -1);
        tests++;
        if (r_n != NPIX || r_done_cyc != NPIX * PERIOD) begin
            fails++;
            $display("FAIL abort_redo got %0d @%0d exp %0d @%0d", r_n, r_done_cyc, NPIX, NPIX * PERIOD);
        end
    endtask

    task automatic test_reset_mid();
        run_tile(12'd0, 8'd10, 8'd20, 1'b0, 1'b0, -1, 0, -1, 5);
        tests++;
        if (r_rst_valid || r_rst_busy) begin
            fails++;
            $display("FAIL rst_mid_async got valid %0d busy %0d exp 0 0", r_rst_valid, r_rst_busy);
        end
        tests++;
        if (r_timeout || r_n != 5 || r_ndone != 0) begin
            fails++;
            $display("FAIL rst_mid got xfers %0d dones %0d exp 5 0", r_n, r_ndone);
        end
        run_tile(12'd0, 8'd10, 8'd20, 1'b0, 1'b0, -1, 0, -1, -1);
        tests++;
        if (r_n != NPIX || r_done_cyc != NPIX * PERIOD) begin
            fails++;
            $display("FAIL rst_redo got %0d @%0d exp %0d @%0d", r_n, r_done_cyc, NPIX, NPIX * PERIOD);
        end
    endtask

    task automatic test_key();
        int n_exp;
        key_rgb = 24'h000102;
        run_tile(12'd0, 8'd10, 8'd20, 1'b0, 1'b0, -1, 0, -1, -1);
        build_expected(12'd0, 8'd10, 8'd20, 1'b0, 1'b0);
`ifdef TILE_BLIT_KEY_EN
        n_exp = NPIX - 1;
`else
        n_exp = NPIX;
`endif
        tests++;
        if (r_timeout || r_n != n_exp || r_ndone != 1) begin
            fails++;
            $display("FAIL key_count got %0d dones %0d exp %0d 1", r_n, r_ndone, n_exp);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests++;
            if (obs_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL key_pix[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
        tests++;
        if (r_done_cyc != NPIX * PERIOD) begin
            fails++;
            $display("FAIL key_done got %0d exp %0d", r_done_cyc, NPIX * PERIOD);
        end
        key_rgb = 24'hFFFFFF;
    endtask

    task automatic test_random();
        logic [11:0] b;
        logic [7:0]  x, y;
        logic        fx, fy;
        int          sa, sl;
        rom_fill_random();
        for (int t = 0; t < 4; t++) begin
            b = 12'($urandom); x = 8'($urandom); y = 8'($urandom);
            fx = 1'($urandom); fy = 1'($urandom);
            sa = int'($urandom_range(0, NPIX - 1));
            sl = int'($urandom_range(0, 6));
            run_tile(b, x, y, fx, fy, sa, sl, -1, -1);
            build_expected(b, x, y, fx, fy);
            tests++;
            if (r_timeout || r_n != exp_q.size() || !r_stable) begin
                fails++;
                $display("FAIL rand%0d_count got %0d stable %0d exp %0d 1", t, r_n, r_stable, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                tests++;
                if (obs_q[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL rand%0d_pix[%0d] got %h exp %h", t, i, obs_q[i], exp_q[i]);
                end
            end
            tests++;
            if (r_done_cyc != NPIX * PERIOD + sl) begin
                fails++;
                $display("FAIL rand%0d_done got %0d exp %0d", t, r_done_cyc, NPIX * PERIOD + sl);
            end
        end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; abort = 1'b0; pix_ready = 1'b1;
        base_addr = '0; x_pos = '0; y_pos = '0; flip_x = 1'b0; flip_y = 1'b0;
        key_rgb = 24'hFFFFFF;
        rom_fill_linear();
        test_reset();
        test_basic();
        test_flip();
        test_stall();
        test_wrap();
        test_abort();
        test_reset_mid();
        test_key();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tile_blitter.md
# tile_blitter

Parametrised tile-to-framebuffer blitter that draws a TILE_W×TILE_H tile of 24-bit RGB pixels, stored as consecutive R,G,B bytes in a byte-wide ROM, at a screen coordinate. It sits between the game/scene controller and the shared VGA write port. It adds configurable tile size and ROM latency, per-tile horizontal/vertical mirroring, a valid/ready pixel handshake, abort, and optional colour-key transparency.

## Interface
- TILE_W, 8, tile width in pixels (≥1)
- TILE_H, 8, tile height in pixels (≥1)
- COORD_W, 8, screen coordinate width
- ADDR_W, 12, ROM byte address width
- ROM_LAT, 1, cycles from rom_addr change to valid rom_data (≥0)
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  request draw; sampled only in IDLE
- abort  in  1  synchronous cancel of the current tile
- base_addr  in  ADDR_W  ROM byte address of pixel (0,0) R byte
- x_pos, y_pos  in  COORD_W  screen origin of tile
- flip_x, flip_y  in  1  mirror horizontally / vertically
- key_rgb  in  24  transparent colour (used only with TILE_BLIT_KEY_EN)
- rom_addr  out  ADDR_W  ROM byte address, registered
- rom_data  in  8  ROM read data
- pix_valid  out  1  pixel presented
- pix_ready  in  1  VGA port accepts pixel
- pix_x, pix_y  out  COORD_W  pixel screen coordinate
- pix_rgb  out  24  {R,G,B}
- busy  out  1  tile in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, FETCH, EMIT, DONE.
- IDLE: on start=1, latch base_addr, x_pos, y_pos, flip_x, flip_y; clear row r and column c; go to FETCH. Inputs may change freely after the start cycle.
- FETCH: read bytes b=0,1,2 (R,G,B) at base + 3·(r·TILE_W + c) + b, modulo 2^ADDR_W. After B is captured, go to EMIT.
- EMIT: pix_valid=1. pix_x = x + (flip_x ? TILE_W−1−c : c), pix_y = y + (flip_y ? TILE_H−1−r : r), both truncated to COORD_W, so they wrap. pix_x, pix_y and pix_rgb are held stable while pix_valid=1 && pix_ready=0.
- On transfer (pix_valid && pix_ready), advance in raster order: c+1, wrapping to 0 with r+1. If the transferred pixel was the last (r=TILE_H−1, c=TILE_W−1), go to DONE; otherwise go to FETCH.
- DONE: assert done for one cycle, then go to IDLE.
- busy=1 in FETCH, EMIT and DONE. start is ignored while busy.
- abort=1 in any non-IDLE state: go to IDLE on the next edge with pix_valid=0 and no done pulse. abort has priority over transfer and over start.
- resetn low mid-tile: outputs return to reset values immediately; state goes to IDLE.

## Timing
- Reset values: rom_addr=0, pix_valid=0, pix_x=0, pix_y=0, pix_rgb=0, busy=0, done=0.
- Each byte is presented on rom_addr for ROM_LAT+1 cycles. rom_data is captured on the edge that ends the last of these cycles, and that same edge moves rom_addr to the next byte.
- Start accepted at edge E: the first R address appears after E. First pix_valid appears 3·(ROM_LAT+1) cycles after E.
- Minimum pixel period with pix_ready tied high: 3·(ROM_LAT+1)+1 cycles. For the defaults that is 7 cycles, giving 64·7 = 448 cycles from start to the done pulse.
- done is asserted the cycle after the last transfer; busy falls the cycle after done.

## Configuration
- TILE_BLIT_KEY_EN defined: in EMIT, if the captured pixel equals key_rgb, pix_valid stays 0 for one cycle and the block advances as if the pixel had been transferred. A keyed last pixel still leads to DONE.
- Not defined: key_rgb is ignored and every pixel is emitted.

## Structure
- Package tile_blit_pkg holds:
  - the state enum
  - BYTES_PER_PIXEL=3
  - typedef rgb_t, a 24-bit packed {r,g,b}
  - a coordinate-mirroring function
- One sub-module, tile_rom_fetch: the byte sequencer with the ROM_LAT wait counter. It takes a pixel base address, returns an rgb_t, and reports capture completion.

## Test plan
- Defaults, ROM model with byte k = k[7:0], base=0, x=10, y=20, pix_ready=1 → 64 pixels; the first is (10,20) rgb 0x000102, the last is (17,27) rgb 0xBDBEBF; done pulses at cycle 448.
- flip_x=1, flip_y=1, same setup → first pixel is (17,27) rgb 0x000102.
- pix_ready held low for 5 cycles on pixel 3 → pix_x, pix_y, pix_rgb stay stable, no pixel is lost, and total time grows by 5.
- x=254, TILE_W=8 → pix_x runs 254,255,0..5 (wrap); base=0xFFF exercises ROM address wrap to 0x000.
- abort during pixel 10, and separately resetn low during EMIT → IDLE with pix_valid=0 and no done pulse. A following start draws a full tile.
- TILE_BLIT_KEY_EN with key_rgb=0x000102 → pixel (0,0) is never presented, and exactly 63 transfers occur before done.
